// File: rtl/reg_wr_arbiter_if.sv
// reg_wr_arbiter_if: requester handshake and register-bank write bus for reg_wr_arbiter.
interface reg_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3
);
    localparam int SRC_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [SRC_W-1:0]          wr_src;
    logic                      locked;
    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, wr_src, locked
    );
    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, wr_src, locked
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin arbiter with bounded burst lock for the register-bank write port.
// Optional conflict counter enabled by defining REG_WR_ARB_PERF_EN.
module reg_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rstn,
`ifdef REG_WR_ARB_PERF_EN
    output logic [15:0]      conflict_cnt,
`endif
    reg_wr_arbiter_if.slave  bus
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int BW    = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d, owner_q, owner_d, win, sel;
    logic [BW-1:0]     burst_q, burst_d;
    logic              wr_en_q, wr_en_d, any, acc, last;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [SRC_W-1:0]  wr_src_q, wr_src_d;

    function automatic logic [SRC_W-1:0] nxt(input logic [SRC_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        win = ptr_q;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                any = 1'b1;
                win = SRC_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        sel     = (state_q == ARB) ? win : owner_q;
        acc     = (state_q == ARB) ? any : bus.req_valid[owner_q];
        last    = !bus.req_lock[owner_q] || (int'(burst_q) + 1 >= MAX_BURST);
        if (state_q == ARB) begin
            if (any && bus.req_lock[win]) begin
                state_d = LOCK;
                owner_d = win;
                burst_d = BW'(1);
            end else if (any) begin
                ptr_d = nxt(win);
            end
        end else if (acc && !last) begin
            burst_d = burst_q + 1'b1;
        end else begin
            // final beat or owner went idle: release so others are not starved
            state_d = ARB;
            ptr_d   = nxt(owner_q);
        end
        wr_en_d   = acc;
        wr_addr_d = acc ? bus.req_addr[int'(sel)*ADDR_W +: ADDR_W] : wr_addr_q;
        wr_data_d = acc ? bus.req_data[int'(sel)*DATA_W +: DATA_W] : wr_data_q;
        wr_src_d  = acc ? sel : wr_src_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            burst_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    // ready is forced low while reset is held so nothing is granted mid-reset
    assign bus.req_ready = (acc && rstn) ? NUM_REQ'(1) << sel : '0;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_src    = wr_src_q;
    assign bus.locked    = (state_q == LOCK);

`ifdef REG_WR_ARB_PERF_EN
    logic [15:0] cnt_q, cnt_d;
    logic        conflict;

    always_comb begin
        conflict = (state_q == ARB) ? ($countones(bus.req_valid) > 1)
                                    : |(bus.req_valid & ~(NUM_REQ'(1) << owner_q));
        cnt_d    = (conflict && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: directed self-checking bench for reg_wr_arbiter (4 requesters, MAX_BURST=4).
module tb_reg_wr_arbiter;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
`ifdef REG_WR_ARB_PERF_EN
    logic [15:0] conflict_cnt;
`endif

    reg_wr_arbiter_if bus ();

    reg_wr_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
`ifdef REG_WR_ARB_PERF_EN
        .conflict_cnt (conflict_cnt),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [3:0] rdy, input string tag);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_lock  = l;
        #1 check({tag, "_rdy"}, 32'(bus.req_ready), 32'(rdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_lock  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*3 +: 3] = 3'(i + 1);
            bus.req_data[i*8 +: 8] = 8'(8'hA3 + i);
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_addr", 32'(bus.wr_addr), 0);
        check("rst_data", 32'(bus.wr_data), 0);
        check("rst_src", 32'(bus.wr_src), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        rstn = 1'b1;

        // single requester
        step(4'b0100, 4'b0000, 4'b0100, "single");
        check("single_wr_en", 32'(bus.wr_en), 1);
        check("single_addr", 32'(bus.wr_addr), 3);
        check("single_data", 32'(bus.wr_data), 32'hA5);
        check("single_src", 32'(bus.wr_src), 2);
        step(4'b1111, 4'b0000, 4'b1000, "ptr3");
        check("ptr3_src", 32'(bus.wr_src), 3);
        step(4'b0000, 4'b0000, 4'b0000, "idle");
        check("idle_wr_en", 32'(bus.wr_en), 0);
        check("idle_hold_addr", 32'(bus.wr_addr), 4);
        check("idle_hold_data", 32'(bus.wr_data), 32'hA6);

        // round-robin from reset
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 4'b0000, 4'(1 << (k % 4)), "rr");
            check("rr_wr_en", 32'(bus.wr_en), 1);
            check("rr_src", 32'(bus.wr_src), 32'(k % 4));
            check("rr_data", 32'(bus.wr_data), 32'(8'hA3 + k % 4));
        end

        // burst cap
        do_reset();
        step(4'b0010, 4'b0010, 4'b0010, "burst1");
        check("burst1_src", 32'(bus.wr_src), 1);
        check("burst1_locked", 32'(bus.locked), 1);
        step(4'b0011, 4'b0010, 4'b0010, "burst2");
        check("burst2_locked", 32'(bus.locked), 1);
        step(4'b0011, 4'b0010, 4'b0010, "burst3");
        check("burst3_locked", 32'(bus.locked), 1);
        step(4'b0011, 4'b0010, 4'b0010, "burst4");
        check("burst4_src", 32'(bus.wr_src), 1);
        check("burst4_locked", 32'(bus.locked), 0);
        step(4'b0011, 4'b0010, 4'b0001, "burst5");
        check("burst5_src", 32'(bus.wr_src), 0);
        check("burst5_locked", 32'(bus.locked), 0);

        // early release
        do_reset();
        step(4'b0100, 4'b0100, 4'b0100, "rel1");
        check("rel1_locked", 32'(bus.locked), 1);
        step(4'b0100, 4'b0100, 4'b0100, "rel2");
        check("rel2_wr_en", 32'(bus.wr_en), 1);
        step(4'b0011, 4'b0000, 4'b0000, "rel3");
        check("rel3_wr_en", 32'(bus.wr_en), 0);
        check("rel3_locked", 32'(bus.locked), 0);
        check("rel3_hold_addr", 32'(bus.wr_addr), 3);
        step(4'b0011, 4'b0000, 4'b0001, "rel4");
        check("rel4_src", 32'(bus.wr_src), 0);

        // reset mid-burst
        do_reset();
        step(4'b0010, 4'b0000, 4'b0010, "mr0");
        step(4'b0100, 4'b0100, 4'b0100, "mr1");
        check("mr1_locked", 32'(bus.locked), 1);
        step(4'b0100, 4'b0100, 4'b0100, "mr2");
        check("mr2_wr_en", 32'(bus.wr_en), 1);
        @(negedge clk);
        rstn = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_lock  = 4'b1111;
        #1;
        check("mr_rst_wr_en", 32'(bus.wr_en), 0);
        check("mr_rst_locked", 32'(bus.locked), 0);
        check("mr_rst_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        rstn = 1'b1;
        bus.req_lock = 4'b0000;
        #1 check("mr_after_ready", 32'(bus.req_ready), 32'b0001);
        @(posedge clk);
        #1 check("mr_after_src", 32'(bus.wr_src), 0);

`ifdef REG_WR_ARB_PERF_EN
        do_reset();
        check("perf_rst", 32'(conflict_cnt), 0);
        step(4'b0011, 4'b0000, 4'b0001, "perf1");
        step(4'b0011, 4'b0000, 4'b0010, "perf2");
        step(4'b0011, 4'b0000, 4'b0001, "perf3");
        check("perf_cnt3", 32'(conflict_cnt), 3);
        repeat (65532) @(posedge clk);
        #1 check("perf_full", 32'(conflict_cnt), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1 check("perf_sat", 32'(conflict_cnt), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
